alu_issue_tx: RTL and testbench
===============================

// Module: alu_issue_tx
// PURPOSE
// - Issue-side transmitter for the issue->ALU instruction interface. Buffers decoded ALU instructions
//   from issue arbitration and drives out_alu_select plus instruction fields toward the ALU input flops,
//   one instruction per cycle, only while the ALU reports ready. Sits between issue arbiter and ALU.
// PARAMETERS
// - DEPTH      4    buffer entries (power of two, >=2)
// - PTR_W      2    log2(DEPTH)
// PORTS
// - clk              in   1   clock
// - rst              in   1   reset, synchronous, active-high
// - in_push_valid    in   1   issue arbiter offers an instruction this cycle
// - out_push_ready   out  1   buffer can accept (= !full)
// - in_wfid          in   6   wavefront id
// - in_instr_pc      in   32  instruction PC
// - in_opcode        in   32  decoded opcode
// - in_imm_value0    in   16  immediate 0
// - in_imm_value1    in   32  immediate 1 / literal
// - in_source1_addr / in_source2_addr / in_source3_addr  in  12 each  source operand addresses
// - in_dest1_addr / in_dest2_addr                        in  12 each  destination addresses
// - in_alu_ready     in   1   ALU can take an instruction next cycle
// - out_alu_select   out  1   one-cycle strobe: fields below valid this cycle
// - out_wfid, out_instr_pc, out_opcode, out_imm_value0, out_imm_value1, out_source1/2/3_addr,
//   out_dest1/2_addr  out  same widths as inputs  registered instruction fields
// - out_count        out  PTR_W+1  entries held (0..DEPTH)
// BEHAVIOUR
// - Reset (sync, rst=1 at edge): pointers/count=0, out_alu_select=0, all out_* fields=0, out_push_ready=1.
// - Push: accepted at edge iff in_push_valid && out_push_ready; 178-bit packed word written at wr_ptr.
// - out_push_ready = !full, from registered count only; no full-and-pop pass-through.
// - Pop: at edge iff count!=0 && in_alu_ready; head word loads output regs, out_alu_select=1 next cycle.
// - Otherwise out_alu_select=0 next cycle; out_* fields hold last issued values (no clear).
// - Latency: push in cycle N -> out_alu_select high in cycle N+2 at earliest (no bypass).
// - Throughput: 1 instr/cycle while in_alu_ready held high and buffer non-empty.
// - Simultaneous push+pop: count unchanged, both pointers advance; legal at any non-full, non-empty count.
// - Push to empty + pop same cycle: pop does not occur (count was 0); entry issues next cycle.
// - Pointers wrap modulo DEPTH; count saturates by construction (push blocked at DEPTH, pop at 0).
// - in_alu_ready low: buffer stalls, contents and order preserved; strict FIFO order, no reordering.
// - rst mid-stream: all buffered entries dropped; in-flight strobe cleared the same edge.
// - Fields at in_* ignored when push not accepted.
// STRUCTURE
// - Shared package: field width constants (WFID_W=6, PC_W=32, OPCODE_W=32, IMM0_W=16, IMM1_W=32,
//   OPADDR_W=12) and ALU_INSTR_W=178 packed-word width; pack/unpack order wfid,pc,opcode,imm0,imm1,
//   src1,src2,src3,dst1,dst2 (MSB->LSB).
// - One sub-module: alu_issue_fifo (generic sync FIFO, WIDTH/DEPTH, push/pop/full/empty/count).
// - Top: packing, pop qualification, output register bank with out_alu_select.
// TESTING
// - Reset: rst=1 2 cycles with in_push_valid=1 -> out_alu_select=0, out_count=0, out_push_ready=1, fields=0.
// - Single issue: push wfid=6'h05, pc=32'h100 at cycle N, in_alu_ready=1 -> strobe only in N+2, out_wfid=5,
//   out_instr_pc=32'h100; fields hold after strobe drops.
// - Fill/stall: in_alu_ready=0, push 5 instrs -> first 4 accepted, out_push_ready=0 after 4th, count=4,
//   5th not stored; raise ready -> 4 strobes consecutive, wfid order 0,1,2,3.
// - Stream: push every cycle, ready=1, 16 instrs -> 16 strobes back-to-back, order kept, count<=1.
// - Ready toggling: ready 1,0,1,0 with 3 queued -> strobes only after ready-high cycles, no loss/duplication.
// - Mid-stream reset: 3 queued, assert rst 1 cycle -> count=0, no further strobes, next push issues normally.

Source files
------------

// File: rtl/alu_issue_tx_pkg.sv
// Shared field widths and the packed instruction word carried from issue arbitration to the ALU.
// Struct member order is the pack order, so wfid lands in the MSBs and dest2 in the LSBs.
package alu_issue_tx_pkg;

    localparam int WFID_W      = 6;
    localparam int PC_W        = 32;
    localparam int OPCODE_W    = 32;
    localparam int IMM0_W      = 16;
    localparam int IMM1_W      = 32;
    localparam int OPADDR_W    = 12;
    localparam int ALU_INSTR_W = WFID_W + PC_W + OPCODE_W + IMM0_W + IMM1_W + 5 * OPADDR_W;

    typedef struct packed {
        logic [WFID_W-1:0]   wfid;
        logic [PC_W-1:0]     pc;
        logic [OPCODE_W-1:0] opcode;
        logic [IMM0_W-1:0]   imm0;
        logic [IMM1_W-1:0]   imm1;
        logic [OPADDR_W-1:0] src1;
        logic [OPADDR_W-1:0] src2;
        logic [OPADDR_W-1:0] src3;
        logic [OPADDR_W-1:0] dst1;
        logic [OPADDR_W-1:0] dst2;
    } alu_instr_t;

endpackage

// File: rtl/alu_issue_tx_fifo.sv
// Generic synchronous FIFO with a registered occupancy count; push and pop are ignored
// when the FIFO is full or empty respectively.
module alu_issue_fifo #(
    parameter int WIDTH = 178,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PTR_W:0]   count_o
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             doPush, doPop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rdPtr_q];
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) wrPtr_d = wrPtr_q + PTR_ONE;
        if (doPop)  rdPtr_d = rdPtr_q + PTR_ONE;
        case ({doPush, doPop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q] <= wdata_i;
    end

endmodule

// File: rtl/alu_issue_tx.sv
// Issue-side transmitter: buffers decoded ALU instructions and issues one per cycle into a
// registered output bank, strobing out_alu_select, whenever the ALU reports ready.
module alu_issue_tx
    import alu_issue_tx_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_push_valid,
    output logic                out_push_ready,
    input  logic [WFID_W-1:0]   in_wfid,
    input  logic [PC_W-1:0]     in_instr_pc,
    input  logic [OPCODE_W-1:0] in_opcode,
    input  logic [IMM0_W-1:0]   in_imm_value0,
    input  logic [IMM1_W-1:0]   in_imm_value1,
    input  logic [OPADDR_W-1:0] in_source1_addr,
    input  logic [OPADDR_W-1:0] in_source2_addr,
    input  logic [OPADDR_W-1:0] in_source3_addr,
    input  logic [OPADDR_W-1:0] in_dest1_addr,
    input  logic [OPADDR_W-1:0] in_dest2_addr,
    input  logic                in_alu_ready,
    output logic                out_alu_select,
    output logic [WFID_W-1:0]   out_wfid,
    output logic [PC_W-1:0]     out_instr_pc,
    output logic [OPCODE_W-1:0] out_opcode,
    output logic [IMM0_W-1:0]   out_imm_value0,
    output logic [IMM1_W-1:0]   out_imm_value1,
    output logic [OPADDR_W-1:0] out_source1_addr,
    output logic [OPADDR_W-1:0] out_source2_addr,
    output logic [OPADDR_W-1:0] out_source3_addr,
    output logic [OPADDR_W-1:0] out_dest1_addr,
    output logic [OPADDR_W-1:0] out_dest2_addr,
    output logic [PTR_W:0]      out_count
);

    alu_instr_t pushWord, headWord;
    alu_instr_t issuedInstr_q, issuedInstr_d;
    logic       aluSelect_q, aluSelect_d;
    logic       fifoFull, fifoEmpty;
    logic       doPush, doPop;

    assign pushWord = '{wfid: in_wfid, pc: in_instr_pc, opcode: in_opcode,
                        imm0: in_imm_value0, imm1: in_imm_value1,
                        src1: in_source1_addr, src2: in_source2_addr, src3: in_source3_addr,
                        dst1: in_dest1_addr, dst2: in_dest2_addr};

    // Ready depends only on registered occupancy, so a full buffer never accepts even while popping.
    assign out_push_ready = !fifoFull;
    assign doPush         = in_push_valid && !fifoFull;
    assign doPop          = !fifoEmpty && in_alu_ready;

    alu_issue_fifo #(
        .WIDTH (ALU_INSTR_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (doPush),
        .wdata_i (pushWord),
        .pop_i   (doPop),
        .rdata_o (headWord),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (out_count)
    );

    // Output fields hold the last issued instruction; only the strobe drops when idle.
    always_comb begin
        aluSelect_d   = doPop;
        issuedInstr_d = issuedInstr_q;
        if (doPop) issuedInstr_d = headWord;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aluSelect_q   <= 1'b0;
            issuedInstr_q <= '0;
        end else begin
            aluSelect_q   <= aluSelect_d;
            issuedInstr_q <= issuedInstr_d;
        end
    end

    assign out_alu_select   = aluSelect_q;
    assign out_wfid         = issuedInstr_q.wfid;
    assign out_instr_pc     = issuedInstr_q.pc;
    assign out_opcode       = issuedInstr_q.opcode;
    assign out_imm_value0   = issuedInstr_q.imm0;
    assign out_imm_value1   = issuedInstr_q.imm1;
    assign out_source1_addr = issuedInstr_q.src1;
    assign out_source2_addr = issuedInstr_q.src2;
    assign out_source3_addr = issuedInstr_q.src3;
    assign out_dest1_addr   = issuedInstr_q.dst1;
    assign out_dest2_addr   = issuedInstr_q.dst2;

endmodule

// File: tb/tb_alu_issue_tx.sv
// Randomized and directed bench for alu_issue_tx against a queue-based transaction model.
module tb_alu_issue_tx;
    import alu_issue_tx_pkg::*;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic                clk;
    logic                rst;
    logic                in_push_valid;
    logic                out_push_ready;
    logic [WFID_W-1:0]   in_wfid;
    logic [PC_W-1:0]     in_instr_pc;
    logic [OPCODE_W-1:0] in_opcode;
    logic [IMM0_W-1:0]   in_imm_value0;
    logic [IMM1_W-1:0]   in_imm_value1;
    logic [OPADDR_W-1:0] in_source1_addr, in_source2_addr, in_source3_addr;
    logic [OPADDR_W-1:0] in_dest1_addr, in_dest2_addr;
    logic                in_alu_ready;
    logic                out_alu_select;
    logic [WFID_W-1:0]   out_wfid;
    logic [PC_W-1:0]     out_instr_pc;
    logic [OPCODE_W-1:0] out_opcode;
    logic [IMM0_W-1:0]   out_imm_value0;
    logic [IMM1_W-1:0]   out_imm_value1;
    logic [OPADDR_W-1:0] out_source1_addr, out_source2_addr, out_source3_addr;
    logic [OPADDR_W-1:0] out_dest1_addr, out_dest2_addr;
    logic [PTR_W:0]      out_count;

    alu_issue_tx #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_push_valid    (in_push_valid),
        .out_push_ready   (out_push_ready),
        .in_wfid          (in_wfid),
        .in_instr_pc      (in_instr_pc),
        .in_opcode        (in_opcode),
        .in_imm_value0    (in_imm_value0),
        .in_imm_value1    (in_imm_value1),
        .in_source1_addr  (in_source1_addr),
        .in_source2_addr  (in_source2_addr),
        .in_source3_addr  (in_source3_addr),
        .in_dest1_addr    (in_dest1_addr),
        .in_dest2_addr    (in_dest2_addr),
        .in_alu_ready     (in_alu_ready),
        .out_alu_select   (out_alu_select),
        .out_wfid         (out_wfid),
        .out_instr_pc     (out_instr_pc),
        .out_opcode       (out_opcode),
        .out_imm_value0   (out_imm_value0),
        .out_imm_value1   (out_imm_value1),
        .out_source1_addr (out_source1_addr),
        .out_source2_addr (out_source2_addr),
        .out_source3_addr (out_source3_addr),
        .out_dest1_addr   (out_dest1_addr),
        .out_dest2_addr   (out_dest2_addr),
        .out_count        (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    alu_instr_t pending[$];
    alu_instr_t expOut;
    logic       expSel;

    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic alu_instr_t randInstr();
        alu_instr_t t;
        t.wfid   = WFID_W'($urandom);
        t.pc     = $urandom;
        t.opcode = $urandom;
        t.imm0   = IMM0_W'($urandom);
        t.imm1   = $urandom;
        t.src1   = OPADDR_W'($urandom);
        t.src2   = OPADDR_W'($urandom);
        t.src3   = OPADDR_W'($urandom);
        t.dst1   = OPADDR_W'($urandom);
        t.dst2   = OPADDR_W'($urandom);
        return t;
    endfunction

    task automatic checkCycle();
        checkOutput("select", 256'(out_alu_select), 256'(expSel));
        checkOutput("count", 256'(out_count), 256'(pending.size()));
        checkOutput("push_ready", 256'(out_push_ready), 256'(pending.size() < DEPTH));
        checkOutput("wfid", 256'(out_wfid), 256'(expOut.wfid));
        checkOutput("pc", 256'(out_instr_pc), 256'(expOut.pc));
        checkOutput("opcode", 256'(out_opcode), 256'(expOut.opcode));
        checkOutput("imm0", 256'(out_imm_value0), 256'(expOut.imm0));
        checkOutput("imm1", 256'(out_imm_value1), 256'(expOut.imm1));
        checkOutput("src1", 256'(out_source1_addr), 256'(expOut.src1));
        checkOutput("src2", 256'(out_source2_addr), 256'(expOut.src2));
        checkOutput("src3", 256'(out_source3_addr), 256'(expOut.src3));
        checkOutput("dst1", 256'(out_dest1_addr), 256'(expOut.dst1));
        checkOutput("dst2", 256'(out_dest2_addr), 256'(expOut.dst2));
    endtask

    // Drive one cycle of inputs, advance the model at the edge, then check just after it.
    task automatic applyStimulus(input logic r, input logic v, input logic rdy,
                                 input alu_instr_t instr);
        bit willPop, willPush;
        rst             = r;
        in_push_valid   = v;
        in_alu_ready    = rdy;
        in_wfid         = instr.wfid;
        in_instr_pc     = instr.pc;
        in_opcode       = instr.opcode;
        in_imm_value0   = instr.imm0;
        in_imm_value1   = instr.imm1;
        in_source1_addr = instr.src1;
        in_source2_addr = instr.src2;
        in_source3_addr = instr.src3;
        in_dest1_addr   = instr.dst1;
        in_dest2_addr   = instr.dst2;
        @(posedge clk);
        if (r) begin
            pending.delete();
            expSel = 1'b0;
            expOut = '0;
        end else begin
            willPop  = (pending.size() != 0) && rdy;
            willPush = v && (pending.size() < DEPTH);
            expSel   = willPop;
            if (willPop)  expOut = pending.pop_front();
            if (willPush) pending.push_back(instr);
        end
        #1;
        checkCycle();
    endtask

    initial begin
        alu_instr_t t;
        expSel = 1'b0;
        expOut = '0;

        // Reset held two cycles while pushes are offered.
        applyStimulus(1'b1, 1'b1, 1'b1, randInstr());
        applyStimulus(1'b1, 1'b1, 1'b1, randInstr());
        checkOutput("reset_count", 256'(out_count), 256'(0));
        checkOutput("reset_ready", 256'(out_push_ready), 256'(1));

        // Single issue: strobe only two cycles after the push.
        t = randInstr();
        t.wfid = 6'h05;
        t.pc   = 32'h100;
        applyStimulus(1'b0, 1'b1, 1'b1, t);
        checkOutput("single_n1_sel", 256'(out_alu_select), 256'(0));
        applyStimulus(1'b0, 1'b0, 1'b1, randInstr());
        checkOutput("single_n2_sel", 256'(out_alu_select), 256'(1));
        checkOutput("single_n2_wfid", 256'(out_wfid), 256'(5));
        checkOutput("single_n2_pc", 256'(out_instr_pc), 256'(32'h100));
        applyStimulus(1'b0, 1'b0, 1'b1, randInstr());
        checkOutput("single_n3_sel", 256'(out_alu_select), 256'(0));
        checkOutput("single_n3_hold", 256'(out_wfid), 256'(5));

        // Fill while stalled, then drain in order.
        for (int i = 0; i < 5; i++) begin
            t = randInstr();
            t.wfid = WFID_W'(i);
            applyStimulus(1'b0, 1'b1, 1'b0, t);
            if (i == 3) begin
                checkOutput("fill_count4", 256'(out_count), 256'(4));
                checkOutput("fill_ready0", 256'(out_push_ready), 256'(0));
            end
        end
        checkOutput("fill_5th_dropped", 256'(out_count), 256'(4));
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, randInstr());
            checkOutput("drain_sel", 256'(out_alu_select), 256'(1));
            checkOutput("drain_wfid", 256'(out_wfid), 256'(i));
        end
        applyStimulus(1'b0, 1'b0, 1'b1, randInstr());
        checkOutput("drain_idle_sel", 256'(out_alu_select), 256'(0));

        // Back-to-back stream.
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 1'b1, randInstr());
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, randInstr());

        // Ready toggling with three queued.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, randInstr());
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'(i % 2 == 0), randInstr());

        // Mid-stream reset drops queued entries, then a fresh push issues normally.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, randInstr());
        applyStimulus(1'b1, 1'b0, 1'b1, randInstr());
        checkOutput("midrst_count", 256'(out_count), 256'(0));
        checkOutput("midrst_sel", 256'(out_alu_select), 256'(0));
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 1'b1, randInstr());
        applyStimulus(1'b0, 1'b1, 1'b1, randInstr());
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 1'b1, randInstr());

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 2) != 0), randInstr());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
